// File: rtl/cu_sequencer_if.sv
// rtl/cu_sequencer_if.sv - memory, decoder and status bundle between sequencer and its environment
interface cu_sequencer_if;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        IR_load;
    logic [2:0]  NS;
    logic        status_load;
    logic [3:0]  alu_status;
    logic        fetch_req;
    logic        ir_valid;
    logic [10:0] opcode;
    logic [4:0]  SB;
    logic [4:0]  SA;
    logic [4:0]  DA;
    logic [11:0] imm;
    logic [3:0]  state;
    logic [3:0]  status;
    logic        pc_inc;
    logic        fault;

    modport master (
        input  mem_data, mem_ready, IR_load, NS, status_load, alu_status,
        output fetch_req, ir_valid, opcode, SB, SA, DA, imm, state, status, pc_inc, fault
    );

    modport slave (
        output mem_data, mem_ready, IR_load, NS, status_load, alu_status,
        input  fetch_req, ir_valid, opcode, SB, SA, DA, imm, state, status, pc_inc, fault
    );
endinterface

// File: rtl/cu_sequencer.sv
// rtl/cu_sequencer.sv - fetch/wait/exec sequencer with exec-cycle watchdog and status latch
module cu_sequencer #(
    parameter int EXEC_LIMIT = 15
) (
    input  logic         clock,
    input  logic         reset,
    cu_sequencer_if.master bus
);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} fsm_t;

    localparam logic [3:0] LIMIT = 4'(EXEC_LIMIT);

    fsm_t        cur, nxt;
    logic [31:0] ir;
    logic [3:0]  state_q;
    logic [3:0]  status_q;
    logic [3:0]  exec_cnt;
    logic        fault_q;

    always_ff @(posedge clock) begin
        if (reset) cur <= S_FETCH;
        else       cur <= nxt;
    end

    // Retirement wins over the watchdog when both land on the same cycle.
    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH: nxt = S_WAIT;
            S_WAIT:  if (bus.mem_ready) nxt = S_EXEC;
            S_EXEC: begin
                if (bus.IR_load)           nxt = S_FETCH;
                else if (exec_cnt == LIMIT) nxt = S_HALT;
            end
            S_HALT:  nxt = S_HALT;
            default: nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ir       <= '0;
            state_q  <= '0;
            status_q <= '0;
            exec_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            case (cur)
                S_WAIT: begin
                    if (bus.mem_ready) begin
                        ir       <= bus.mem_data;
                        state_q  <= '0;
                        exec_cnt <= '0;
                    end
                end
                S_EXEC: begin
                    if (bus.status_load) status_q <= bus.alu_status;
                    if (bus.IR_load) begin
                        state_q <= '0;
                    end else begin
                        state_q  <= {1'b0, bus.NS};
                        exec_cnt <= exec_cnt + 4'd1;
                        if (exec_cnt == LIMIT) fault_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are decoded from the FSM and forced low while reset is held.
    assign bus.fetch_req = (cur == S_FETCH) && !reset;
    assign bus.ir_valid  = (cur == S_EXEC) && !reset;
    assign bus.pc_inc    = (cur == S_EXEC) && bus.IR_load && !reset;
    assign bus.fault     = fault_q;
    assign bus.state     = state_q;
    assign bus.status    = status_q;

    assign bus.opcode = ir[31:21];
    assign bus.SB     = ir[20:16];
    assign bus.SA     = ir[9:5];
    assign bus.DA     = ir[4:0];
    assign bus.imm    = ir[21:10];
endmodule

// File: tb/tb_cu_sequencer.sv
// tb/tb_cu_sequencer.sv - randomized instruction-level bench for cu_sequencer
module tb_cu_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;

    cu_sequencer_if bus();

    cu_sequencer #(.EXEC_LIMIT(15)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int pc_pulses;

    logic [31:0] m_ir;
    logic [3:0]  m_status;
    logic [2:0]  ns_tab [16];
    logic        sl_tab [16];
    logic [3:0]  as_tab [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_fields(input string pfx);
        check({pfx, "_opcode"}, 32'(bus.opcode), 32'(m_ir[31:21]));
        check({pfx, "_sb"},     32'(bus.SB),     32'(m_ir[20:16]));
        check({pfx, "_sa"},     32'(bus.SA),     32'(m_ir[9:5]));
        check({pfx, "_da"},     32'(bus.DA),     32'(m_ir[4:0]));
        check({pfx, "_imm"},    32'(bus.imm),    32'(m_ir[21:10]));
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 16; i++) begin
            ns_tab[i] = 3'($urandom);
            sl_tab[i] = 1'($urandom);
            as_tab[i] = 4'($urandom);
        end
    endtask

    // Reset with every input trying to provoke activity, including a memory reply.
    task automatic do_reset();
        reset           = 1'b1;
        bus.mem_ready   = 1'b1;
        bus.mem_data    = $urandom;
        bus.IR_load     = 1'b1;
        bus.status_load = 1'b1;
        bus.alu_status  = 4'($urandom);
        bus.NS          = 3'($urandom);
        #1;
        check("rst_fetch_req", 32'(bus.fetch_req), 32'(0));
        check("rst_ir_valid",  32'(bus.ir_valid),  32'(0));
        check("rst_pc_inc",    32'(bus.pc_inc),    32'(0));
        tick();
        reset         = 1'b0;
        bus.mem_ready = 1'b0;
        m_ir          = '0;
        m_status      = '0;
        #1;
        check("rst_state",    32'(bus.state),    32'(0));
        check("rst_status",   32'(bus.status),   32'(0));
        check("rst_fault",    32'(bus.fault),    32'(0));
        check("rst_ir_valid2", 32'(bus.ir_valid), 32'(0));
        check_fields("rst");
    endtask

    // One instruction: fetch, `stalls` wait cycles, then `steps` non-retiring exec cycles
    // followed by a retire; steps > 15 never retires and must trip the watchdog.
    task automatic do_instr(input int stalls, input logic [31:0] word, input int steps, input int abort_k);
        int          last;
        logic [2:0]  prev_ns;
        prev_ns = '0;

        bus.mem_ready   = 1'($urandom);
        bus.mem_data    = $urandom;
        bus.IR_load     = 1'($urandom);
        bus.status_load = 1'b1;
        bus.alu_status  = 4'($urandom);
        bus.NS          = 3'($urandom);
        #1;
        check("fetch_req",     32'(bus.fetch_req), 32'(1));
        check("fetch_ir_valid", 32'(bus.ir_valid), 32'(0));
        check("fetch_pc_inc",  32'(bus.pc_inc),    32'(0));
        check("fetch_status",  32'(bus.status),    32'(m_status));
        tick();

        for (int i = 0; i < stalls; i++) begin
            bus.mem_ready   = 1'b0;
            bus.mem_data    = $urandom;
            bus.status_load = 1'b1;
            bus.alu_status  = 4'hF;
            bus.IR_load     = 1'($urandom);
            #1;
            check("wait_fetch_req", 32'(bus.fetch_req), 32'(0));
            check("wait_ir_valid",  32'(bus.ir_valid),  32'(0));
            check("wait_pc_inc",    32'(bus.pc_inc),    32'(0));
            check("wait_status",    32'(bus.status),    32'(m_status));
            check_fields("wait");
            tick();
        end

        bus.mem_ready   = 1'b1;
        bus.mem_data    = word;
        bus.status_load = 1'b1;
        bus.alu_status  = 4'hF;
        #1;
        check("ready_fetch_req", 32'(bus.fetch_req), 32'(0));
        check("ready_ir_valid",  32'(bus.ir_valid),  32'(0));
        tick();
        m_ir = word;

        last = (steps > 15) ? 15 : steps;
        for (int k = 0; k <= last; k++) begin
            bus.mem_ready   = 1'($urandom);
            bus.mem_data    = $urandom;
            bus.IR_load     = (k == steps);
            bus.NS          = ns_tab[k];
            bus.status_load = sl_tab[k];
            bus.alu_status  = as_tab[k];
            #1;
            check("exec_state",     32'(bus.state),     (k == 0) ? 32'(0) : 32'(prev_ns));
            check("exec_ir_valid",  32'(bus.ir_valid),  32'(1));
            check("exec_pc_inc",    32'(bus.pc_inc),    32'(k == steps));
            check("exec_fetch_req", 32'(bus.fetch_req), 32'(0));
            check("exec_status",    32'(bus.status),    32'(m_status));
            check("exec_fault",     32'(bus.fault),     32'(0));
            check_fields("exec");
            if (bus.pc_inc) pc_pulses++;
            if (k == abort_k) begin
                do_reset();
                return;
            end
            tick();
            if (sl_tab[k]) m_status = as_tab[k];
            prev_ns = ns_tab[k];
        end

        if (steps > 15) begin
            for (int i = 0; i < 4; i++) begin
                bus.IR_load     = 1'($urandom);
                bus.mem_ready   = 1'($urandom);
                bus.status_load = 1'b1;
                bus.alu_status  = 4'($urandom);
                #1;
                check("halt_fault",     32'(bus.fault),     32'(1));
                check("halt_fetch_req", 32'(bus.fetch_req), 32'(0));
                check("halt_ir_valid",  32'(bus.ir_valid),  32'(0));
                check("halt_pc_inc",    32'(bus.pc_inc),    32'(0));
                check("halt_status",    32'(bus.status),    32'(m_status));
                tick();
            end
        end
    endtask

    initial begin
        bus.mem_data    = '0;
        bus.mem_ready   = 1'b0;
        bus.IR_load     = 1'b0;
        bus.NS          = '0;
        bus.status_load = 1'b0;
        bus.alu_status  = '0;
        m_ir            = '0;
        m_status        = '0;
        pc_pulses       = 0;

        do_reset();

        fill_rand();
        do_instr(0, 32'h8B02_0020, 0, -1);
        check("add_opcode", 32'(bus.opcode), 32'h458);
        check("add_sb",     32'(bus.SB),     32'd2);
        check("add_sa",     32'(bus.SA),     32'd1);
        check("add_da",     32'(bus.DA),     32'd0);

        fill_rand();
        ns_tab[0] = 3'd3;
        ns_tab[1] = 3'd5;
        pc_pulses = 0;
        do_instr(1, $urandom, 2, -1);
        check("multi_pc_pulses", 32'(pc_pulses), 32'd1);

        fill_rand();
        do_instr(6, $urandom, 1, -1);

        fill_rand();
        sl_tab[0] = 1'b1;
        as_tab[0] = 4'b0101;
        sl_tab[1] = 1'b0;
        do_instr(2, $urandom, 1, -1);
        check("status_latched", 32'(bus.status), 32'h5);

        fill_rand();
        do_instr(3, $urandom, 15, -1);

        for (int n = 0; n < 25; n++) begin
            fill_rand();
            do_instr($urandom_range(0, 4), $urandom, $urandom_range(0, 15), -1);
        end

        fill_rand();
        do_instr(1, $urandom, 16, -1);
        do_reset();

        fill_rand();
        ns_tab[0] = 3'd5;
        sl_tab[0] = 1'b1;
        as_tab[0] = 4'b0011;
        do_instr(0, $urandom, 5, 1);

        fill_rand();
        do_instr(1, $urandom, 3, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cu_sequencer.md
CU_SEQUENCER -- requirements
Module: cu_sequencer

Interface
REQ-001 The block SHALL have the parameter EXEC_LIMIT, default 15, giving the maximum number of EXEC cycles allowed per instruction before a fault is raised.
REQ-002 The block SHALL have the port clock  in  1  system clock; all state changes on the rising edge.
REQ-003 The block SHALL have the port reset  in  1  synchronous, active-high reset.
REQ-004 The block SHALL have the port mem_data  in  32  instruction word returned by memory.
REQ-005 The block SHALL have the port mem_ready  in  1  mem_data valid this cycle.
REQ-006 The block SHALL have the port IR_load  in  1  from the active decoder's control word; 1 = current instruction completes this cycle.
REQ-007 The block SHALL have the port NS  in  3  next micro-state from the active decoder.
REQ-008 The block SHALL have the port status_load  in  1  from the control word; latch ALU flags.
REQ-009 The block SHALL have the port alu_status  in  4  ALU flags {V,C,N,Z}.
REQ-010 The block SHALL have the port fetch_req  out  1  request the next instruction word.
REQ-011 The block SHALL have the port ir_valid  out  1  IR holds an instruction being executed.
REQ-012 The block SHALL have the port opcode  out  11  IR[31:21].
REQ-013 The block SHALL have the port SB  out  5  IR[20:16], Rm.
REQ-014 The block SHALL have the port SA  out  5  IR[9:5], Rn.
REQ-015 The block SHALL have the port DA  out  5  IR[4:0], Rd.
REQ-016 The block SHALL have the port imm  out  12  IR[21:10].
REQ-017 The block SHALL have the port state  out  4  current micro-state fed to the decoders.
REQ-018 The block SHALL have the port status  out  4  latched {V,C,N,Z}.
REQ-019 The block SHALL have the port pc_inc  out  1  one-cycle pulse when an instruction retires.
REQ-020 The block SHALL have the port fault  out  1  sticky; EXEC_LIMIT was exceeded.

Function
REQ-021 The block SHALL implement a 4-state FSM with the states FETCH, WAIT, EXEC and HALT.
REQ-022 In FETCH, fetch_req SHALL be 1 for exactly one cycle, after which the FSM SHALL go unconditionally to WAIT; mem_ready is ignored in FETCH.
REQ-023 In WAIT with mem_ready=1, the block SHALL load mem_data into the 32-bit IR, set state to 0 and go to EXEC; with mem_ready=0 it SHALL hold WAIT with IR unchanged.
REQ-024 opcode, SA, SB, DA and imm SHALL be combinational slices of the IR and SHALL be valid from the first EXEC cycle.
REQ-025 ir_valid SHALL be 1 only in EXEC.
REQ-026 In EXEC with IR_load=1, the block SHALL go to FETCH, set state to 0 and pulse pc_inc=1 for that cycle.
REQ-027 In EXEC with IR_load=0, the block SHALL set state to {1'b0,NS} and remain in EXEC.
REQ-028 The exec counter SHALL be 4 bits wide, cleared on entry to EXEC, and incremented on each EXEC cycle with IR_load=0.
REQ-029 If the exec counter equals EXEC_LIMIT and IR_load=0, the block SHALL go to HALT and set fault=1; IR_load=1 in the same cycle takes precedence (retire, no fault).
REQ-030 HALT SHALL be absorbing: fetch_req=0, ir_valid=0, pc_inc=0, fault=1; only reset exits HALT.
REQ-031 The block SHALL latch status from alu_status at the clock edge when status_load=1 in EXEC; status_load=1 in any other state SHALL be ignored and status SHALL hold.
REQ-032 When status_load=1 and IR_load=1 occur in the same cycle, both SHALL take effect.
REQ-033 pc_inc SHALL be asserted only in EXEC with IR_load=1, never in any other state.
REQ-034 All outputs other than the IR slices SHALL be registered or decoded from FSM state only, with no combinational path from mem_data.

Reset
REQ-035 When reset=1 at a clock edge, the block SHALL move to FETCH from any state, including mid-WAIT, mid-EXEC and HALT.
REQ-036 On reset, IR SHALL be set to 0, state to 0, status to 0, the exec counter to 0 and fault to 0.
REQ-037 On reset, fetch_req, ir_valid and pc_inc SHALL be 0 during the reset cycle.
REQ-038 In the first cycle after reset is released, fetch_req SHALL be 1.
REQ-039 A mem_ready arriving in the same cycle as reset SHALL be discarded.

Verification
REQ-040 Single-cycle instruction: after reset, return mem_data=0x8B020020 with mem_ready=1 in WAIT, then IR_load=1 in the first EXEC cycle -> opcode=0x458, SB=2, SA=1, DA=0, state=0, pc_inc pulses, and fetch_req=1 on the next cycle.
REQ-041 Multi-state instruction: NS=3 then NS=5 with IR_load=0, then IR_load=1 -> state sequence 0,3,5,0, with exactly one pc_inc pulse.
REQ-042 Memory stall: hold mem_ready=0 for 6 cycles in WAIT -> fetch_req is high for 1 cycle only, IR is unchanged and ir_valid=0 until mem_ready=1.
REQ-043 Status: status_load=1 with alu_status=4'b0101 in EXEC -> status=0101 next cycle; status_load=1 with alu_status=1111 in WAIT -> status stays 0101.
REQ-044 Watchdog: hold IR_load=0 for 16 EXEC cycles -> fault=1, FSM in HALT, and fetch_req stays 0; apply reset -> fault=0 and fetch_req=1 in the next cycle.
REQ-045 Reset mid-EXEC: assert reset with state=5 and status=0011 -> next cycle state=0, status=0 and ir_valid=0.
